router_sched: RTL and testbench
===============================

Name: router_sched

Overview:
- Crossbar scheduler for the router.
- Watches the input FIFO empty flags, the destination of each head message and the output FIFO full flags.
- Grants one input→output transfer at a time using round-robin order.
- Drives the input FIFO pops, the output FIFO pushes and the crossbar select indices.
- Sits between the per-port input/output FIFOs and the combinational crossbar mux inside the router.

Parameters:
- NUM_PORTS, 5, number of router ports including NI (valid 2..8).
- DST_W, 3, width of port index and destination field (≥ clog2(NUM_PORTS)).
- WAIT_MAX, 64, S_WAIT cycles before the head message is dropped; 0 disables the timeout.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- arst  in  1  asynchronous reset, active-high.
- srst  in  1  synchronous reset, active-high; same effect as arst at the next clk edge.
- in_mty  in  NUM_PORTS  input FIFO empty flags; bit i = port i.
- in_dst  in  NUM_PORTS*DST_W  destination index of each input FIFO head (first-word-fall-through); port i at [i*DST_W +: DST_W].
- out_full  in  NUM_PORTS  output FIFO full flags.
- in_rd  out  NUM_PORTS  input FIFO pop, one-hot or zero.
- out_wr  out  NUM_PORTS  output FIFO push, one-hot or zero.
- sel_in  out  DST_W  crossbar input select.
- sel_out  out  DST_W  crossbar output select.
- stall  out  1  high while in S_WAIT (head-of-line blocked).
- drop_pulse  out  1  one-cycle pulse when a message is discarded.
- drop_cnt  out  CNT_W  saturating count of discarded messages.

Behaviour:
- Reset (arst or srst): state=S_RESET, rr_ptr=0, cur_in=0, cur_out=0, wait_cnt=0, drop_cnt=0; all outputs 0.
- Outputs are a Moore decode of the registered state, cur_in and cur_out; there are no combinational paths from inputs to in_rd/out_wr.
- S_RESET: always goes to S_ARB on the next cycle.
- S_ARB, port search:
  - Scan ports rr_ptr, rr_ptr+1, … modulo NUM_PORTS.
  - Pick the first i with in_mty[i]=0.
  - None found: stay in S_ARB.
- S_ARB, on a pick: latch cur_in=i and cur_out=in_dst[i], then branch:
  - cur_out ≥ NUM_PORTS → S_DROP.
  - out_full[cur_out]=1 → S_WAIT, wait_cnt=0.
  - otherwise → S_XFER.
- S_XFER (exactly one cycle):
  - in_rd[cur_in]=1, out_wr[cur_out]=1, sel_in=cur_in, sel_out=cur_out.
  - rr_ptr=(cur_in+1) mod NUM_PORTS.
  - Next state S_ARB.
  - Throughput is therefore one message per 2 cycles.
- S_WAIT:
  - stall=1; sel_in/sel_out hold cur_in/cur_out; no rd/wr.
  - out_full[cur_out]=0 → S_XFER.
  - Otherwise, WAIT_MAX≠0 and wait_cnt==WAIT_MAX-1 → S_DROP.
  - Otherwise wait_cnt++.
  - The input is locked: no other port is served while waiting.
- S_DROP (one cycle):
  - in_rd[cur_in]=1, out_wr=0, drop_pulse=1.
  - drop_cnt increments, saturating at all-ones.
  - rr_ptr advances as in S_XFER.
  - Next state S_ARB.
- out_full cannot rise between S_ARB/S_WAIT and S_XFER, because only this block pushes to output FIFOs. No recheck is done in S_XFER.
- Self-loop (cur_out==cur_in) is legal and transfers normally.
- The in_mty/in_dst of the granted port are not re-sampled after S_ARB.
- arst mid-transfer returns to S_RESET immediately and deasserts rd/wr the same cycle.
- Illegal state encodings → S_RESET.

Decomposition:
- Package router_pkg holds:
  - state encodings S_RESET=0, S_ARB=1, S_XFER=2, S_WAIT=3, S_DROP=4 (3-bit);
  - port index constants SEL_N=0, SEL_W=1, SEL_E=2, SEL_S=3, SEL_NI=4;
  - the default NUM_PORTS/DST_W values.
- Sub-module rr_pick: combinational rotating priority picker.
  - Inputs: request vector and pointer.
  - Outputs: found flag and index.
  - Reused later by the output-side arbiter.

Test Plan:
- Post-reset idle: arst pulse, all in_mty=1 → state S_ARB, in_rd=0, out_wr=0, drop_cnt=0 for 20 cycles.
- Single transfer:
  - Stimulus: port 1 non-empty, in_dst[1]=3, out_full=0.
  - Response: S_ARB picks port 1; next cycle in_rd=5'b00010, out_wr=5'b01000, sel_in=1, sel_out=3; rr_ptr becomes 2.
- Round-robin fairness:
  - Stimulus: ports 0, 2 and 4 permanently non-empty, all destined to port 1.
  - Response: grant order 0, 2, 4, 0, 2, 4; one out_wr pulse every 2 cycles.
- Blocking and release:
  - Stimulus: port 0 to dst 2 with out_full[2]=1 for 10 cycles, then 0.
  - Response: stall=1 for 10 cycles; then one S_XFER with out_wr[2]=1; drop_cnt stays 0.
- Timeout drop:
  - Stimulus: WAIT_MAX=4, out_full[2] held 1.
  - Response: stall for 4 cycles; then in_rd[0]=1, out_wr=0, drop_pulse=1, drop_cnt=1.
- Illegal destination and mid-op reset:
  - in_dst[3]=6 → immediate drop (in_rd[3]=1, drop_pulse=1).
  - arst asserted during S_XFER → in_rd and out_wr go 0 in the same cycle, and state returns to S_RESET.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router crossbar scheduler and its helpers.
package router_pkg;

    localparam int NUM_PORTS_DEF = 5;
    localparam int DST_W_DEF     = 3;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_ARB   = 3'd1,
        S_XFER  = 3'd2,
        S_WAIT  = 3'd3,
        S_DROP  = 3'd4
    } state_t;

    localparam logic [2:0] SEL_N  = 3'd0;
    localparam logic [2:0] SEL_W  = 3'd1;
    localparam logic [2:0] SEL_E  = 3'd2;
    localparam logic [2:0] SEL_S  = 3'd3;
    localparam logic [2:0] SEL_NI = 3'd4;

endpackage

// File: rtl/router_sched_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Walk the ring from ptr; the first hit wins and later hits are masked.
    always_comb begin
        int c;
        logic hit;
        found = 1'b0;
        idx   = {IW{1'b0}};
        c     = 0;
        hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            c     = (int'(ptr) + k >= N) ? int'(ptr) + k - N : int'(ptr) + k;
            hit   = req[c] & ~found;
            idx   = hit ? IW'(c) : idx;
            found = found | req[c];
        end
    end

endmodule

// File: rtl/router_sched.sv
// Crossbar scheduler: grants one input-to-output transfer at a time in round-robin
// order, holding a blocked head in S_WAIT and discarding it on timeout or bad destination.
module router_sched
    import router_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int DST_W     = DST_W_DEF,
    parameter int WAIT_MAX  = 64,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       srst,
    input  logic [NUM_PORTS-1:0]       in_mty,
    input  logic [NUM_PORTS*DST_W-1:0] in_dst,
    input  logic [NUM_PORTS-1:0]       out_full,
    output logic [NUM_PORTS-1:0]       in_rd,
    output logic [NUM_PORTS-1:0]       out_wr,
    output logic [DST_W-1:0]           sel_in,
    output logic [DST_W-1:0]           sel_out,
    output logic                       stall,
    output logic                       drop_pulse,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_t             state_r, state_n;
    logic [DST_W-1:0]   rr_ptr_r, rr_ptr_n;
    logic [DST_W-1:0]   cur_in_r, cur_in_n;
    logic [DST_W-1:0]   cur_out_r, cur_out_n;
    logic [WAIT_W-1:0]  wait_cnt_r, wait_cnt_n;
    logic [CNT_W-1:0]   drop_cnt_r, drop_cnt_n;

    logic               pick_found_s;
    logic [DST_W-1:0]   pick_idx_s;
    logic [DST_W-1:0]   pick_dst_s;
    logic               pick_full_s;
    logic               cur_full_s;

    function automatic logic [DST_W-1:0] ring_next(input logic [DST_W-1:0] p);
        return (int'(p) >= NUM_PORTS - 1) ? {DST_W{1'b0}} : p + DST_W'(1);
    endfunction

    rr_pick #(.N(NUM_PORTS), .IW(DST_W)) u_pick (
        .req   (~in_mty),
        .ptr   (rr_ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Mux out the picked head's destination and the full flags it and the locked output see.
    always_comb begin
        pick_dst_s  = {DST_W{1'b0}};
        pick_full_s = 1'b0;
        cur_full_s  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pick_dst_s = (int'(pick_idx_s) == i) ? in_dst[i*DST_W +: DST_W] : pick_dst_s;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            pick_full_s = (int'(pick_dst_s) == i) ? out_full[i] : pick_full_s;
            cur_full_s  = (int'(cur_out_r) == i) ? out_full[i] : cur_full_s;
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_n    = state_r;
        rr_ptr_n   = rr_ptr_r;
        cur_in_n   = cur_in_r;
        cur_out_n  = cur_out_r;
        wait_cnt_n = wait_cnt_r;
        drop_cnt_n = drop_cnt_r;
        case (state_r)
            S_RESET: state_n = S_ARB;
            S_ARB: begin
                if (pick_found_s) begin
                    cur_in_n  = pick_idx_s;
                    cur_out_n = pick_dst_s;
                    if (int'(pick_dst_s) >= NUM_PORTS) begin
                        state_n = S_DROP;
                    end else if (pick_full_s) begin
                        state_n    = S_WAIT;
                        wait_cnt_n = {WAIT_W{1'b0}};
                    end else begin
                        state_n = S_XFER;
                    end
                end else begin
                    state_n = S_ARB;
                end
            end
            S_XFER: begin
                rr_ptr_n = ring_next(cur_in_r);
                state_n  = S_ARB;
            end
            S_WAIT: begin
                if (!cur_full_s) begin
                    state_n = S_XFER;
                end else if ((WAIT_MAX != 0) && (wait_cnt_r == WAIT_W'(WAIT_MAX - 1))) begin
                    state_n = S_DROP;
                end else begin
                    wait_cnt_n = wait_cnt_r + WAIT_W'(1);
                end
            end
            S_DROP: begin
                rr_ptr_n   = ring_next(cur_in_r);
                drop_cnt_n = (drop_cnt_r == {CNT_W{1'b1}}) ? drop_cnt_r : drop_cnt_r + CNT_W'(1);
                state_n    = S_ARB;
            end
            default: state_n = S_RESET;
        endcase
    end

    // State and datapath registers with async and sync reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r    <= S_RESET;
            rr_ptr_r   <= {DST_W{1'b0}};
            cur_in_r   <= {DST_W{1'b0}};
            cur_out_r  <= {DST_W{1'b0}};
            wait_cnt_r <= {WAIT_W{1'b0}};
            drop_cnt_r <= {CNT_W{1'b0}};
        end else if (srst) begin
            state_r    <= S_RESET;
            rr_ptr_r   <= {DST_W{1'b0}};
            cur_in_r   <= {DST_W{1'b0}};
            cur_out_r  <= {DST_W{1'b0}};
            wait_cnt_r <= {WAIT_W{1'b0}};
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_n;
            rr_ptr_r   <= rr_ptr_n;
            cur_in_r   <= cur_in_n;
            cur_out_r  <= cur_out_n;
            wait_cnt_r <= wait_cnt_n;
            drop_cnt_r <= drop_cnt_n;
        end
    end

    // Moore output decode; async reset clears state so rd/wr drop immediately.
    always_comb begin
        in_rd      = {NUM_PORTS{1'b0}};
        out_wr     = {NUM_PORTS{1'b0}};
        sel_in     = {DST_W{1'b0}};
        sel_out    = {DST_W{1'b0}};
        stall      = 1'b0;
        drop_pulse = 1'b0;
        case (state_r)
            S_XFER: begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    in_rd[i]  = (int'(cur_in_r) == i);
                    out_wr[i] = (int'(cur_out_r) == i);
                end
                sel_in  = cur_in_r;
                sel_out = cur_out_r;
            end
            S_WAIT: begin
                stall   = 1'b1;
                sel_in  = cur_in_r;
                sel_out = cur_out_r;
            end
            S_DROP: begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    in_rd[i] = (int'(cur_in_r) == i);
                end
                sel_in     = cur_in_r;
                drop_pulse = 1'b1;
            end
            default: begin
                in_rd = {NUM_PORTS{1'b0}};
            end
        endcase
    end

    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_router_sched.sv
// Directed, table-driven bench for router_sched with hand sequences for waiting,
// timeout drop and asynchronous reset mid-transfer.
module tb_router_sched;

    logic        clk;
    logic        arst;
    logic        srst;
    logic [4:0]  in_mty;
    logic [14:0] in_dst;
    logic [4:0]  out_full;

    logic [4:0]  in_rd, out_wr;
    logic [2:0]  sel_in, sel_out;
    logic        stall, drop_pulse;
    logic [15:0] drop_cnt;

    logic [4:0]  t_rd, t_wr;
    logic [2:0]  t_si, t_so;
    logic        t_stall, t_drop;
    logic [15:0] t_cnt;

    int n_cmp = 0;
    int n_err = 0;

    router_sched dut (
        .clk(clk), .arst(arst), .srst(srst), .in_mty(in_mty), .in_dst(in_dst),
        .out_full(out_full), .in_rd(in_rd), .out_wr(out_wr), .sel_in(sel_in),
        .sel_out(sel_out), .stall(stall), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    router_sched #(.WAIT_MAX(4)) dut_t (
        .clk(clk), .arst(arst), .srst(srst), .in_mty(in_mty), .in_dst(in_dst),
        .out_full(out_full), .in_rd(t_rd), .out_wr(t_wr), .sel_in(t_si),
        .sel_out(t_so), .stall(t_stall), .drop_pulse(t_drop), .drop_cnt(t_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        srst;
        logic [4:0]  mty;
        logic [14:0] dst;
        logic [4:0]  full;
        logic [4:0]  e_rd;
        logic [4:0]  e_wr;
        logic [2:0]  e_si;
        logic [2:0]  e_so;
        logic        e_stall;
        logic        e_drop;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input string f, input logic [15:0] a, input logic [15:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, f, a, e);
        end
    endtask

    task automatic cmp_all(input string nm,
                           input logic [4:0] ar, input logic [4:0] aw, input logic [2:0] asi,
                           input logic [2:0] aso, input logic ast, input logic adr, input logic [15:0] ac,
                           input logic [4:0] er, input logic [4:0] ew, input logic [2:0] esi,
                           input logic [2:0] eso, input logic est, input logic edr, input logic [15:0] ec);
        chk(nm, "in_rd",      16'(ar),  16'(er));
        chk(nm, "out_wr",     16'(aw),  16'(ew));
        chk(nm, "sel_in",     16'(asi), 16'(esi));
        chk(nm, "sel_out",    16'(aso), 16'(eso));
        chk(nm, "stall",      16'(ast), 16'(est));
        chk(nm, "drop_pulse", 16'(adr), 16'(edr));
        chk(nm, "drop_cnt",   ac,       ec);
    endtask

    task automatic em(input string nm, input logic [4:0] er, input logic [4:0] ew, input logic [2:0] esi,
                      input logic [2:0] eso, input logic est, input logic edr, input logic [15:0] ec);
        cmp_all(nm, in_rd, out_wr, sel_in, sel_out, stall, drop_pulse, drop_cnt,
                er, ew, esi, eso, est, edr, ec);
    endtask

    task automatic et(input string nm, input logic [4:0] er, input logic [4:0] ew, input logic [2:0] esi,
                      input logic [2:0] eso, input logic est, input logic edr, input logic [15:0] ec);
        cmp_all(nm, t_rd, t_wr, t_si, t_so, t_stall, t_drop, t_cnt,
                er, ew, esi, eso, est, edr, ec);
    endtask

    task automatic do_reset();
        in_mty   = 5'b11111;
        in_dst   = 15'h0000;
        out_full = 5'b00000;
        srst     = 1'b0;
        arst     = 1'b1;
        tick();
        arst     = 1'b0;
    endtask

    localparam logic [14:0] D_ALL1 = 15'b001_001_001_001_001;
    localparam logic [14:0] D_P1_3 = 15'h0018;
    localparam logic [14:0] D_P3_6 = 15'h0C00;
    localparam logic [14:0] D_P2_2 = 15'h0080;
    localparam logic [14:0] D_P0_2 = 15'h0002;

    initial begin
        // srst, mty, dst, full | rd, wr, si, so, stall, drop, cnt
        tbl.push_back(vec_t'{1'b0, 5'b11111, 15'h0000, 5'b00000, 5'b00000, 5'b00000, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0});
        tbl.push_back(vec_t'{1'b0, 5'b11101, D_P1_3,   5'b00000, 5'b00010, 5'b01000, 3'd1, 3'd3, 1'b0, 1'b0, 16'd0});
        tbl.push_back(vec_t'{1'b0, 5'b11111, D_P1_3,   5'b00000, 5'b00000, 5'b00000, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0});
        tbl.push_back(vec_t'{1'b1, 5'b01010, D_ALL1,   5'b00000, 5'b00000, 5'b00000, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0});
        tbl.push_back(vec_t'{1'b0, 5'b01010, D_ALL1,   5'b00000, 5'b00000, 5'b00000, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0});
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(vec_t'{1'b0, 5'b01010, D_ALL1, 5'b00000, 5'b00001, 5'b00010, 3'd0, 3'd1, 1'b0, 1'b0, 16'd0});
            tbl.push_back(vec_t'{1'b0, 5'b01010, D_ALL1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0});
            tbl.push_back(vec_t'{1'b0, 5'b01010, D_ALL1, 5'b00000, 5'b00100, 5'b00010, 3'd2, 3'd1, 1'b0, 1'b0, 16'd0});
            tbl.push_back(vec_t'{1'b0, 5'b01010, D_ALL1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0});
            tbl.push_back(vec_t'{1'b0, 5'b01010, D_ALL1, 5'b00000, 5'b10000, 5'b00010, 3'd4, 3'd1, 1'b0, 1'b0, 16'd0});
            if (r == 0) begin
                tbl.push_back(vec_t'{1'b0, 5'b01010, D_ALL1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0});
            end
        end
        tbl.push_back(vec_t'{1'b0, 5'b10111, D_P3_6,   5'b00000, 5'b00000, 5'b00000, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0});
        tbl.push_back(vec_t'{1'b0, 5'b10111, D_P3_6,   5'b00000, 5'b01000, 5'b00000, 3'd3, 3'd0, 1'b0, 1'b1, 16'd0});
        tbl.push_back(vec_t'{1'b0, 5'b11111, 15'h0000, 5'b00000, 5'b00000, 5'b00000, 3'd0, 3'd0, 1'b0, 1'b0, 16'd1});
        tbl.push_back(vec_t'{1'b0, 5'b11011, D_P2_2,   5'b00000, 5'b00100, 5'b00100, 3'd2, 3'd2, 1'b0, 1'b0, 16'd1});
        tbl.push_back(vec_t'{1'b0, 5'b11111, 15'h0000, 5'b00000, 5'b00000, 5'b00000, 3'd0, 3'd0, 1'b0, 1'b0, 16'd1});

        // Power-on reset and idle
        in_mty = 5'b11111; in_dst = 15'h0000; out_full = 5'b00000; srst = 1'b0;
        arst = 1'b1;
        tick();
        tick();
        em("reset", 5'b0, 5'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0);
        arst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            em("idle", 5'b0, 5'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0);
        end

        // Table: single transfer, round-robin fairness, bad destination, self-loop
        foreach (tbl[i]) begin
            srst     = tbl[i].srst;
            in_mty   = tbl[i].mty;
            in_dst   = tbl[i].dst;
            out_full = tbl[i].full;
            tick();
            em($sformatf("vec%0d", i), tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_si, tbl[i].e_so,
               tbl[i].e_stall, tbl[i].e_drop, tbl[i].e_cnt);
        end
        srst = 1'b0;

        // Head-of-line block for 10 cycles, then release
        do_reset();
        tick();
        in_mty = 5'b11110; in_dst = D_P0_2; out_full = 5'b00100;
        for (int k = 0; k < 10; k++) begin
            tick();
            em("block", 5'b0, 5'b0, 3'd0, 3'd2, 1'b1, 1'b0, 16'd0);
        end
        out_full = 5'b00000;
        tick();
        em("release", 5'b00001, 5'b00100, 3'd0, 3'd2, 1'b0, 1'b0, 16'd0);
        in_mty = 5'b11111;
        tick();
        em("after_rel", 5'b0, 5'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0);

        // Timeout drop on the WAIT_MAX=4 instance
        do_reset();
        tick();
        in_mty = 5'b11110; in_dst = D_P0_2; out_full = 5'b00100;
        for (int k = 0; k < 4; k++) begin
            tick();
            et("to_wait", 5'b0, 5'b0, 3'd0, 3'd2, 1'b1, 1'b0, 16'd0);
        end
        tick();
        et("to_drop", 5'b00001, 5'b0, 3'd0, 3'd0, 1'b0, 1'b1, 16'd0);
        in_mty = 5'b11111;
        tick();
        et("to_after", 5'b0, 5'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'd1);
        out_full = 5'b00000;

        // Async reset during S_XFER
        do_reset();
        tick();
        in_mty = 5'b11101; in_dst = D_P1_3;
        tick();
        em("pre_arst", 5'b00010, 5'b01000, 3'd1, 3'd3, 1'b0, 1'b0, 16'd0);
        #2;
        arst = 1'b1;
        #1;
        em("arst_now", 5'b0, 5'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0);
        tick();
        arst = 1'b0;
        tick();
        em("post_rst", 5'b0, 5'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0);
        tick();
        em("post_xfer", 5'b00010, 5'b01000, 3'd1, 3'd3, 1'b0, 1'b0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
